fault_sim_sequencer: RTL

Controller for a combinational circuit-under-test (CUT) with fault-injection control lines.
- Applies one latched test vector to the CUT, first fault-free, then with each fault line inverted in turn.
- Samples the CUT output for each pass into a response word and flags which faults the vector detects.
- Sits between the fault-grading control logic and the CUT. This hardware replaces a hand-written per-vector fault-sim sequence.

---
 rtl/fault_sim_sequencer_if.sv | 32 +++
 rtl/fault_sim_sequencer.sv | 103 ++++++++++
 2 files changed

// File: rtl/fault_sim_sequencer_if.sv
// Control-side bus of the fault-sim sequencer: run request and vector in, status and results out.
// FSS_DETECT_COUNT_EN adds the det_count result field.
interface fault_sim_sequencer_if #(
    parameter int N_IN    = 4,
    parameter int N_FAULT = 3
);
    logic                           start;
    logic [N_IN-1:0]                test_vec;
    logic                           busy;
    logic                           done;
    logic [N_FAULT:0]               word;
    logic [N_FAULT-1:0]             detected;
`ifdef FSS_DETECT_COUNT_EN
    logic [$clog2(N_FAULT+1)-1:0]   det_count;
`endif

    modport master (
        output start, test_vec,
        input  busy, done, word, detected
`ifdef FSS_DETECT_COUNT_EN
        , input det_count
`endif
    );

    modport slave (
        input  start, test_vec,
        output busy, done, word, detected
`ifdef FSS_DETECT_COUNT_EN
        , output det_count
`endif
    );
endinterface

// File: rtl/fault_sim_sequencer.sv
// Applies one latched vector to a CUT fault-free and then with each fault line inverted in turn.
// Optional macro FSS_DETECT_COUNT_EN adds det_count (popcount of detected).
module fault_sim_sequencer #(
    parameter int                 N_IN       = 4,
    parameter int                 N_FAULT    = 3,
    parameter logic [N_FAULT-1:0] FAULT_SAFE = 3'b110,
    parameter int                 SETTLE     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    fault_sim_sequencer_if.slave   bus,
    output logic [N_IN-1:0]        cut_in,
    output logic [N_FAULT-1:0]     fault_ctl,
    input  logic                   cut_out
);
    localparam int IDX_W = $clog2(N_FAULT + 1);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_FIRST   = IDX_W'(N_FAULT);

    typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, FIN} state_t;

    state_t           state;
    // idx is the word bit of the current pass: N_FAULT for fault-free, then the fault index
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;

`ifdef FSS_DETECT_COUNT_EN
    function automatic logic [IDX_W-1:0] popcount(input logic [N_FAULT-1:0] v);
        logic [IDX_W-1:0] n;
        n = '0;
        for (int i = 0; i < N_FAULT; i++)
            n = n + IDX_W'(v[i]);
        return n;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            cut_in       <= '0;
            fault_ctl    <= FAULT_SAFE;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.word     <= '0;
            bus.detected <= '0;
`ifdef FSS_DETECT_COUNT_EN
            bus.det_count <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= APPLY;
                        idx          <= IDX_FIRST;
                        cnt          <= '0;
                        cut_in       <= bus.test_vec;
                        fault_ctl    <= FAULT_SAFE;
                        bus.busy     <= 1'b1;
                        bus.word     <= '0;
                        bus.detected <= '0;
`ifdef FSS_DETECT_COUNT_EN
                        bus.det_count <= '0;
`endif
                    end
                end
                APPLY: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    bus.word[idx] <= cut_out;
                    if (idx != '0) begin
                        idx       <= idx - IDX_W'(1);
                        fault_ctl <= FAULT_SAFE ^ (N_FAULT'(1) << (idx - IDX_W'(1)));
                        state     <= APPLY;
                    end else begin
                        fault_ctl <= FAULT_SAFE;
                        state     <= FIN;
                    end
                end
                FIN: begin
                    fault_ctl    <= FAULT_SAFE;
                    bus.detected <= {N_FAULT{bus.word[N_FAULT]}} ^ bus.word[N_FAULT-1:0];
`ifdef FSS_DETECT_COUNT_EN
                    bus.det_count <= popcount({N_FAULT{bus.word[N_FAULT]}} ^ bus.word[N_FAULT-1:0]);
`endif
                    bus.done     <= 1'b1;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
